// File: rtl/ring_pkg.sv
// Shared ring packet layout and route codes.
// Used by the input buffer and the switch allocator.
package ring_pkg;

    localparam int PKT_W     = 49;
    localparam int VALID_BIT = 48;
    localparam int AGE_MSB   = 47;
    localparam int AGE_LSB   = 32;
    localparam int DEST_MSB  = 31;
    localparam int DEST_LSB  = 16;
    localparam int PAY_MSB   = 15;
    localparam int PAY_LSB   = 0;
    localparam int AGE_W     = 16;
    localparam int ROUTE_W   = 16;

    localparam logic [15:0] FWD_CODE   = 16'h0001;
    localparam logic [15:0] EJECT_CODE = 16'h0002;

    function automatic logic [ROUTE_W-1:0] route_of(
        input logic [15:0] dest,
        input logic [15:0] local_id,
        input logic [15:0] fwd,
        input logic [15:0] eject
    );
        return (dest == local_id) ? eject : fwd;
    endfunction

endpackage

// File: rtl/ring_input_buffer_if.sv
// Write-and-grant channel into one priority class.
// Master supplies packet and grant, slave returns ready.
interface ring_input_buffer_if
    import ring_pkg::*;
#(
    parameter int W = PKT_W
);

    logic [W-1:0] packet;
    logic         ready;
    logic [15:0]  grant_pos;
    logic         grant_valid;

    modport master (
        output packet,
        output grant_pos,
        output grant_valid,
        input  ready
    );

    modport slave (
        input  packet,
        input  grant_pos,
        input  grant_valid,
        output ready
    );

endinterface

// File: rtl/ring_slot_bank.sv
// One priority class: slots, route codes, free-slot pick,
// occupancy and grant clear.
module ring_slot_bank
    import ring_pkg::*;
#(
    parameter int          PACKET_SIZE = PKT_W,
    parameter int          BUFFER_SIZE = 4,
    parameter logic [15:0] LOCAL_ID    = 16'h0000,
    parameter logic [15:0] FWD_PORT    = FWD_CODE,
    parameter logic [15:0] EJECT_PORT  = EJECT_CODE,
    parameter bit          STAMP_AGE   = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    ring_input_buffer_if.slave                 chan,
    input  logic [AGE_W-1:0]                   age,
    output logic [PACKET_SIZE*BUFFER_SIZE-1:0] slots,
    output logic [ROUTE_W*BUFFER_SIZE-1:0]     routes,
    output logic [2:0]                         occupancy,
    output logic                               grant_bad
);

    localparam int IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    logic [PACKET_SIZE-1:0] slot_q  [BUFFER_SIZE];
    logic [ROUTE_W-1:0]     route_q [BUFFER_SIZE];
    logic [2:0]             occ_q;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   free_ok;
    logic                   wr;
    logic                   gnt_ok;
    logic [PACKET_SIZE-1:0] wr_pkt;
    logic [ROUTE_W-1:0]     wr_route;

    // Ready is gated by rst_n so it drops the moment reset asserts.
    assign chan.ready = rst_n && (occ_q < 3'(BUFFER_SIZE));
    assign occupancy  = occ_q;

    always_comb begin
        free_idx = '0;
        free_ok  = 1'b0;
        for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
            if (!slot_q[i][VALID_BIT]) begin
                free_idx = IDX_W'(i);
                free_ok  = 1'b1;
            end
        end
    end

    assign gnt_idx = chan.grant_pos[IDX_W-1:0];

    always_comb begin
        gnt_ok = 1'b0;
        if (chan.grant_valid && (chan.grant_pos < 16'(BUFFER_SIZE))) begin
            gnt_ok = slot_q[gnt_idx][VALID_BIT];
        end
    end

    assign grant_bad = chan.grant_valid && !gnt_ok;
    assign wr        = chan.packet[VALID_BIT] && chan.ready && free_ok;

    always_comb begin
        wr_pkt = chan.packet;
        wr_pkt[AGE_MSB:AGE_LSB] = STAMP_AGE ? age
                                            : chan.packet[AGE_MSB:AGE_LSB];
    end

    assign wr_route = route_of(chan.packet[DEST_MSB:DEST_LSB],
                               LOCAL_ID, FWD_PORT, EJECT_PORT);

    // The freed slot is still valid this cycle, so free_idx never aliases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                slot_q[i]  <= '0;
                route_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            if (gnt_ok) begin
                slot_q[gnt_idx]  <= '0;
                route_q[gnt_idx] <= '0;
            end
            if (wr) begin
                slot_q[free_idx]  <= wr_pkt;
                route_q[free_idx] <= wr_route;
            end
            occ_q <= occ_q + {2'b00, wr} - {2'b00, gnt_ok};
        end
    end

    for (genvar g = 0; g < BUFFER_SIZE; g++) begin : g_flat
        assign slots[g*PACKET_SIZE +: PACKET_SIZE] = slot_q[g];
        assign routes[g*ROUTE_W +: ROUTE_W]        = route_q[g];
    end

endmodule

// File: rtl/ring_input_buffer.sv
// Ring router input buffer: high class fed by the ring,
// low class fed by the local core, shared age counter.
module ring_input_buffer
    import ring_pkg::*;
#(
    parameter int          PACKET_SIZE = PKT_W,
    parameter int          BUFFER_SIZE = 4,
    parameter logic [15:0] LOCAL_ID    = 16'h0000,
    parameter logic [15:0] FWD_PORT    = FWD_CODE,
    parameter logic [15:0] EJECT_PORT  = EJECT_CODE
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [PACKET_SIZE-1:0]             ring_in_packet,
    output logic                               ring_in_ready,
    input  logic [PACKET_SIZE-1:0]             local_in_packet,
    output logic                               local_in_ready,
    input  logic [15:0]                        grant_pos,
    input  logic                               grant_valid,
    input  logic                               grant_in_high,
    output logic [PACKET_SIZE*BUFFER_SIZE-1:0] buffer_high_prior,
    output logic [PACKET_SIZE*BUFFER_SIZE-1:0] buffer_low_prior,
    output logic [16*BUFFER_SIZE-1:0]          buffer_high_prior_route_info,
    output logic [16*BUFFER_SIZE-1:0]          buffer_low_prior_route_info,
    output logic [2:0]                         high_occupancy,
    output logic [2:0]                         low_occupancy,
    output logic                               grant_error
);

    logic [AGE_W-1:0] age_q;
    logic             hi_bad;
    logic             lo_bad;
    logic             err_q;

    ring_input_buffer_if #(.W(PACKET_SIZE)) hi_if ();
    ring_input_buffer_if #(.W(PACKET_SIZE)) lo_if ();

    assign hi_if.packet      = ring_in_packet;
    assign hi_if.grant_pos   = grant_pos;
    assign hi_if.grant_valid = grant_valid && grant_in_high;
    assign lo_if.packet      = local_in_packet;
    assign lo_if.grant_pos   = grant_pos;
    assign lo_if.grant_valid = grant_valid && !grant_in_high;

    assign ring_in_ready  = hi_if.ready;
    assign local_in_ready = lo_if.ready;
    assign grant_error    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
            err_q <= 1'b0;
        end else begin
            age_q <= age_q + 16'd1;
            err_q <= err_q || hi_bad || lo_bad;
        end
    end

    ring_slot_bank #(
        .PACKET_SIZE (PACKET_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE),
        .LOCAL_ID    (LOCAL_ID),
        .FWD_PORT    (FWD_PORT),
        .EJECT_PORT  (EJECT_PORT),
        .STAMP_AGE   (1'b0)
    ) u_high (
        .clk       (clk),
        .rst_n     (rst_n),
        .chan      (hi_if),
        .age       (age_q),
        .slots     (buffer_high_prior),
        .routes    (buffer_high_prior_route_info),
        .occupancy (high_occupancy),
        .grant_bad (hi_bad)
    );

    ring_slot_bank #(
        .PACKET_SIZE (PACKET_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE),
        .LOCAL_ID    (LOCAL_ID),
        .FWD_PORT    (FWD_PORT),
        .EJECT_PORT  (EJECT_PORT),
        .STAMP_AGE   (1'b1)
    ) u_low (
        .clk       (clk),
        .rst_n     (rst_n),
        .chan      (lo_if),
        .age       (age_q),
        .slots     (buffer_low_prior),
        .routes    (buffer_low_prior_route_info),
        .occupancy (low_occupancy),
        .grant_bad (lo_bad)
    );

endmodule

// File: tb/tb_ring_input_buffer.sv
// Directed bench for ring_input_buffer.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_ring_input_buffer;

    localparam int P = 49;
    localparam int B = 4;

    logic           clk;
    logic           rst_n;
    logic [P-1:0]   lpkt;
    logic           ghigh;
    logic           lready;
    logic [P*B-1:0] hbuf;
    logic [P*B-1:0] lbuf;
    logic [16*B-1:0] hroute;
    logic [16*B-1:0] lroute;
    logic [2:0]     hocc;
    logic [2:0]     locc;
    logic           gerr;

    int n_chk  = 0;
    int n_pass = 0;

    ring_input_buffer_if drv ();

    ring_input_buffer dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .ring_in_packet               (drv.packet),
        .ring_in_ready                (drv.ready),
        .local_in_packet              (lpkt),
        .local_in_ready               (lready),
        .grant_pos                    (drv.grant_pos),
        .grant_valid                  (drv.grant_valid),
        .grant_in_high                (ghigh),
        .buffer_high_prior            (hbuf),
        .buffer_low_prior             (lbuf),
        .buffer_high_prior_route_info (hroute),
        .buffer_low_prior_route_info  (lroute),
        .high_occupancy               (hocc),
        .low_occupancy                (locc),
        .grant_error                  (gerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [P-1:0] pkt(input logic [15:0] age,
                                         input logic [15:0] dest,
                                         input logic [15:0] pay);
        return {1'b1, age, dest, pay};
    endfunction

    function automatic logic [P-1:0] hs(input int i);
        return hbuf[i*P +: P];
    endfunction

    function automatic logic [P-1:0] ls(input int i);
        return lbuf[i*P +: P];
    endfunction

    function automatic logic [15:0] hr(input int i);
        return hroute[i*16 +: 16];
    endfunction

    function automatic logic [15:0] lr(input int i);
        return lroute[i*16 +: 16];
    endfunction

    task automatic idle();
        drv.packet      = '0;
        drv.grant_pos   = '0;
        drv.grant_valid = 1'b0;
        lpkt            = '0;
        ghigh           = 1'b0;
    endtask

    // Returns at a negedge with the age counter at 0.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic ring_wr(input logic [P-1:0] p);
        drv.packet = p;
        @(negedge clk);
        drv.packet = '0;
    endtask

    task automatic local_wr(input logic [P-1:0] p);
        lpkt = p;
        @(negedge clk);
        lpkt = '0;
    endtask

    task automatic grant(input logic [15:0] pos, input logic high);
        drv.grant_pos   = pos;
        drv.grant_valid = 1'b1;
        ghigh           = high;
        @(negedge clk);
        drv.grant_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        chk("rst_hocc", 64'(hocc), 64'd0);
        chk("rst_locc", 64'(locc), 64'd0);
        chk("rst_rrdy", 64'(drv.ready), 64'd0);
        chk("rst_lrdy", 64'(lready), 64'd0);
        chk("rst_gerr", 64'(gerr), 64'd0);
        chk("rst_hbuf", 64'(hbuf[63:0]), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rrdy", 64'(drv.ready), 64'd1);
        chk("rel_lrdy", 64'(lready), 64'd1);

        // Ring packet to a remote node keeps its timestamp and forwards
        do_reset();
        ring_wr(pkt(16'h0005, 16'h0003, 16'hABCD));
        chk("s1_slot0", 64'(hs(0)), 64'h1_0005_0003_ABCD);
        chk("s1_route", 64'(hr(0)), 64'h0001);
        chk("s1_hocc", 64'(hocc), 64'd1);
        chk("s1_slot1", 64'(hs(1)), 64'd0);
        chk("s1_route1", 64'(hr(1)), 64'd0);

        // Local packet addressed here is stamped and ejects
        do_reset();
        repeat (16) @(negedge clk);
        local_wr(pkt(16'h7777, 16'h0000, 16'h1234));
        chk("s2_slot0", 64'(ls(0)), 64'h1_0010_0000_1234);
        chk("s2_route", 64'(lr(0)), 64'h0002);
        chk("s2_locc", 64'(locc), 64'd1);

        // Fill, drop, grant, refill
        do_reset();
        for (int i = 1; i <= 4; i++) ring_wr(pkt(16'h0, 16'h0003, 16'(i)));
        chk("s3_rrdy0", 64'(drv.ready), 64'd0);
        chk("s3_hocc4", 64'(hocc), 64'd4);
        ring_wr(pkt(16'h0, 16'h0003, 16'h0005));
        chk("s3_drop3", 64'(hs(3)), 64'h1_0000_0003_0004);
        chk("s3_drop0", 64'(hs(0)), 64'h1_0000_0003_0001);
        chk("s3_hocc_d", 64'(hocc), 64'd4);
        grant(16'd2, 1'b1);
        chk("s3_rrdy1", 64'(drv.ready), 64'd1);
        chk("s3_clr2", 64'(hs(2)), 64'd0);
        chk("s3_rclr2", 64'(hr(2)), 64'd0);
        chk("s3_hocc3", 64'(hocc), 64'd3);
        ring_wr(pkt(16'h0, 16'h0000, 16'h0006));
        chk("s3_refill", 64'(hs(2)), 64'h1_0000_0000_0006);
        chk("s3_rroute", 64'(hr(2)), 64'h0002);
        chk("s3_hocc4b", 64'(hocc), 64'd4);

        // Invalid packets are ignored
        do_reset();
        ring_wr({1'b0, 16'h1, 16'h3, 16'hBEEF});
        chk("inv_hocc", 64'(hocc), 64'd0);
        chk("inv_slot0", 64'(hs(0)), 64'd0);

        // Grant and write together
        do_reset();
        for (int i = 1; i <= 3; i++) ring_wr(pkt(16'h0, 16'h0003, 16'(i)));
        drv.packet      = pkt(16'h0, 16'h0003, 16'h0009);
        drv.grant_pos   = 16'd0;
        drv.grant_valid = 1'b1;
        ghigh           = 1'b1;
        @(negedge clk);
        idle();
        chk("s4_slot3", 64'(hs(3)), 64'h1_0000_0003_0009);
        chk("s4_slot0", 64'(hs(0)), 64'd0);
        chk("s4_slot1", 64'(hs(1)), 64'h1_0000_0003_0002);
        chk("s4_hocc", 64'(hocc), 64'd3);
        chk("s4_gerr", 64'(gerr), 64'd0);

        // Illegal grants
        do_reset();
        grant(16'd1, 1'b0);
        chk("s5_gerr", 64'(gerr), 64'd1);
        chk("s5_locc", 64'(locc), 64'd0);
        local_wr(pkt(16'h0, 16'h0009, 16'h00AA));
        grant(16'd7, 1'b0);
        chk("s5_locc1", 64'(locc), 64'd1);
        chk("s5_route", 64'(lr(0)), 64'h0001);
        chk("s5_keep", 64'(ls(0)), {15'd0, pkt(16'h0001, 16'h0009, 16'h00AA)});
        repeat (3) @(negedge clk);
        chk("s5_sticky", 64'(gerr), 64'd1);
        do_reset();
        chk("s5_clear", 64'(gerr), 64'd0);

        // Age counter wrap, then reset in the middle of a write
        repeat (65535) @(negedge clk);
        local_wr(pkt(16'h0, 16'h0005, 16'h0001));
        local_wr(pkt(16'h0, 16'h0005, 16'h0002));
        chk("s6_ffff", 64'(ls(0)), 64'h1_FFFF_0005_0001);
        chk("s6_wrap", 64'(ls(1)), 64'h1_0000_0005_0002);
        drv.packet = pkt(16'h1, 16'h0003, 16'h0033);
        lpkt       = pkt(16'h0, 16'h0003, 16'h0044);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_alocc", 64'(locc), 64'd0);
        chk("s6_ahocc", 64'(hocc), 64'd0);
        chk("s6_albuf", 64'(lbuf[63:0]), 64'd0);
        chk("s6_alrte", 64'(lroute), 64'd0);
        chk("s6_arrdy", 64'(drv.ready), 64'd0);
        chk("s6_alrdy", 64'(lready), 64'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("s6_rhocc", 64'(hocc), 64'd0);
        chk("s6_rlocc", 64'(locc), 64'd0);
        chk("s6_rrdy", 64'(drv.ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
